// File: rtl/i2c_command_queue.sv
// i2c_command_queue: host-side command front-end for i2c_master.
//
// Buffers register read/write commands from a valid/ready host channel in a
// small circular FIFO, hands them one at a time to i2c_master, and watches
// master_busy for completion. Read results go back on a valid/ready response
// channel. Writes produce no response.
//
// Optional build macro: I2C_COMMAND_QUEUE_TIMEOUT_EN
//   Defined   - a busy-wait counter aborts a transfer after TIMEOUT_CYCLES clocks in
//               LAUNCH/WAIT_DONE and returns response_error=1 with response_data=0.
//   Undefined - transfers wait indefinitely; response_error is always 0.
//
// Ports:
//   clock, reset_n              clock (rising edge), asynchronous active-low reset
//   command_*                   host command channel (valid/ready)
//   response_*                  read result / error channel (valid/ready)
//   master_enable .. _address   drive i2c_master inputs
//   master_busy, master_miso_data  from i2c_master
//   fifo_level                  number of commands queued
//   idle                        FIFO empty and FSM in IDLE

module i2c_command_queue #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REGISTER_WIDTH = 8,
  parameter int unsigned ADDRESS_WIDTH  = 7,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                            clock,
  input  logic                            reset_n,
  // Host command channel
  input  logic                            command_valid,
  output logic                            command_ready,
  input  logic                            command_read_write,
  input  logic [ADDRESS_WIDTH-1:0]        command_device_address,
  input  logic [REGISTER_WIDTH-1:0]       command_register_address,
  input  logic [DATA_WIDTH-1:0]           command_data,
  // Host response channel
  output logic                            response_valid,
  input  logic                            response_ready,
  output logic [DATA_WIDTH-1:0]           response_data,
  output logic                            response_error,
  // i2c_master side
  output logic                            master_enable,
  output logic                            master_read_write,
  output logic [DATA_WIDTH-1:0]           master_mosi_data,
  output logic [REGISTER_WIDTH-1:0]       master_register_address,
  output logic [ADDRESS_WIDTH-1:0]        master_device_address,
  input  logic                            master_busy,
  input  logic [DATA_WIDTH-1:0]           master_miso_data,
  // Status
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            idle
);

  localparam int unsigned PtrWidth   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelWidth = PtrWidth + 1;

  typedef struct packed {
    logic                      read_write;
    logic [ADDRESS_WIDTH-1:0]  device_address;
    logic [REGISTER_WIDTH-1:0] register_address;
    logic [DATA_WIDTH-1:0]     data;
  } command_t;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StRespond
  } state_e;

  state_e                 state_q;
  command_t               fifo_mem [FIFO_DEPTH];
  command_t               head;
  logic [PtrWidth-1:0]    wr_ptr_q;
  logic [PtrWidth-1:0]    rd_ptr_q;
  logic [LevelWidth-1:0]  level_q;
  logic                   push;
  logic                   pop;
  logic                   fifo_empty;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------

  // Full blocks a push even when a pop happens in the same cycle.
  assign command_ready = (level_q != LevelWidth'(FIFO_DEPTH));
  assign fifo_empty    = (level_q == '0);
  assign push          = command_valid && command_ready;
  assign pop           = (state_q == StIdle) && !fifo_empty && !master_busy;
  assign head          = fifo_mem[rd_ptr_q];
  assign fifo_level    = level_q;
  assign idle          = fifo_empty && (state_q == StIdle);

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{
        read_write:       command_read_write,
        device_address:   command_device_address,
        register_address: command_register_address,
        data:             command_data
      };
    end
  end

  // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional busy-wait timeout
  // --------------------------------------------------------------------------

`ifdef I2C_COMMAND_QUEUE_TIMEOUT_EN
  localparam int unsigned CountWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CountWidth-1:0] timeout_count_q;
  logic                  timeout_hit;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in LAUNCH/WAIT_DONE.
  assign timeout_hit = (timeout_count_q == CountWidth'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_count_q <= '0;
    end else if (pop) begin
      timeout_count_q <= '0;
    end else if ((state_q == StLaunch) || (state_q == StWaitDone)) begin
      timeout_count_q <= timeout_count_q + 1'b1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------

  // The pop loads the master_* holding registers on LAUNCH entry; enable follows
  // one clock later so address/data are already settled when i2c_master sees it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q                 <= StIdle;
      master_enable           <= 1'b0;
      master_read_write       <= 1'b0;
      master_mosi_data        <= '0;
      master_register_address <= '0;
      master_device_address   <= '0;
      response_valid          <= 1'b0;
      response_data           <= '0;
      response_error          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            master_read_write       <= head.read_write;
            master_device_address   <= head.device_address;
            master_register_address <= head.register_address;
            master_mosi_data        <= head.data;
            state_q                 <= StLaunch;
          end
        end

        StLaunch: begin
`ifdef I2C_COMMAND_QUEUE_TIMEOUT_EN
          if (timeout_hit) begin
            master_enable  <= 1'b0;
            response_data  <= '0;
            response_error <= 1'b1;
            response_valid <= 1'b1;
            state_q        <= StRespond;
          end else
`endif
          if (master_busy) begin
            master_enable <= 1'b0;
            state_q       <= StWaitDone;
          end else begin
            master_enable <= 1'b1;
          end
        end

        StWaitDone: begin
`ifdef I2C_COMMAND_QUEUE_TIMEOUT_EN
          if (timeout_hit) begin
            response_data  <= '0;
            response_error <= 1'b1;
            response_valid <= 1'b1;
            state_q        <= StRespond;
          end else
`endif
          if (!master_busy) begin
            if (master_read_write) begin
              response_data  <= master_miso_data;
              response_error <= 1'b0;
              response_valid <= 1'b1;
              state_q        <= StRespond;
            end else begin
              state_q <= StIdle;
            end
          end
        end

        StRespond: begin
          // Response fields stay frozen until the host accepts them.
          if (response_ready) begin
            response_valid <= 1'b0;
            response_error <= 1'b0;
            state_q        <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_command_queue.sv
module tb_i2c_command_queue;

  logic       clock;
  logic       reset_n;
  logic       command_valid;
  logic       command_ready;
  logic       command_read_write;
  logic [6:0] command_device_address;
  logic [7:0] command_register_address;
  logic [7:0] command_data;
  logic       response_valid;
  logic       response_ready;
  logic [7:0] response_data;
  logic       response_error;
  logic       master_enable;
  logic       master_read_write;
  logic [7:0] master_mosi_data;
  logic [7:0] master_register_address;
  logic [6:0] master_device_address;
  logic       master_busy;
  logic [7:0] master_miso_data;
  logic [2:0] fifo_level;
  logic       idle;

  int checks   = 0;
  int failures = 0;

  // Simple register-file model of the attached I2C slave.
  logic [7:0] slave_mem [256];
  logic       cap_rw;
  logic [6:0] cap_dev;
  logic [7:0] cap_reg;
  logic [7:0] cap_data;

  logic       hold_enable_seen;
  logic       hold_data_moved;
  logic       hold_valid_dropped;

  i2c_command_queue #(
    .DATA_WIDTH     (8),
    .REGISTER_WIDTH (8),
    .ADDRESS_WIDTH  (7),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .command_valid            (command_valid),
    .command_ready            (command_ready),
    .command_read_write       (command_read_write),
    .command_device_address   (command_device_address),
    .command_register_address (command_register_address),
    .command_data             (command_data),
    .response_valid           (response_valid),
    .response_ready           (response_ready),
    .response_data            (response_data),
    .response_error           (response_error),
    .master_enable            (master_enable),
    .master_read_write        (master_read_write),
    .master_mosi_data         (master_mosi_data),
    .master_register_address  (master_register_address),
    .master_device_address    (master_device_address),
    .master_busy              (master_busy),
    .master_miso_data         (master_miso_data),
    .fifo_level               (fifo_level),
    .idle                     (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] dat);
    command_valid            = 1'b1;
    command_read_write       = rw;
    command_device_address   = dev;
    command_register_address = rg;
    command_data             = dat;
  endtask

  // Acts as i2c_master + slave for one transfer: waits for enable, raises busy,
  // completes the register access, then drops busy and lets WAIT_DONE sample it.
  task automatic serve_one(input int busy_cycles);
    int n = 0;
    while (!master_enable && n < 20) begin
      tick();
      n++;
    end
    check("enable_seen", {31'd0, master_enable}, 32'd1);
    cap_rw   = master_read_write;
    cap_dev  = master_device_address;
    cap_reg  = master_register_address;
    cap_data = master_mosi_data;
    master_busy = 1'b1;
    tick();
    check("enable_drop", {31'd0, master_enable}, 32'd0);
    repeat (busy_cycles) tick();
    if (cap_rw) master_miso_data = slave_mem[cap_reg];
    else        slave_mem[cap_reg] = cap_data;
    master_busy = 1'b0;
    tick();
  endtask

  initial begin
    reset_n                  = 1'b0;
    command_valid            = 1'b0;
    command_read_write       = 1'b0;
    command_device_address   = '0;
    command_register_address = '0;
    command_data             = '0;
    response_ready           = 1'b0;
    master_busy              = 1'b0;
    master_miso_data         = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready",  {31'd0, command_ready},  32'd1);
    check("rst_rvalid", {31'd0, response_valid}, 32'd0);
    check("rst_rdata",  {24'd0, response_data},  32'd0);
    check("rst_rerr",   {31'd0, response_error}, 32'd0);
    check("rst_enable", {31'd0, master_enable},  32'd0);
    check("rst_level",  {29'd0, fifo_level},     32'd0);
    check("rst_idle",   {31'd0, idle},           32'd1);
    reset_n = 1'b1;
    tick();

    // Single write 11/05/A5: latency, holding registers, no response
    set_cmd(1'b0, 7'h11, 8'h05, 8'hA5);
    tick();                                  // edge N: push
    command_valid = 1'b0;
    check("w1_level_push", {29'd0, fifo_level},    32'd1);
    check("w1_idle_busy",  {31'd0, idle},          32'd0);
    tick();                                  // edge N+1: pop into holding regs
    check("w1_en_n1",  {31'd0, master_enable},           32'd0);
    check("w1_dev",    {25'd0, master_device_address},   32'h11);
    check("w1_reg",    {24'd0, master_register_address}, 32'h05);
    check("w1_data",   {24'd0, master_mosi_data},        32'hA5);
    check("w1_rw",     {31'd0, master_read_write},       32'd0);
    check("w1_level0", {29'd0, fifo_level},              32'd0);
    tick();                                  // edge N+2: enable
    check("w1_en_n2",  {31'd0, master_enable},           32'd1);
    tick();
    check("w1_en_hold", {31'd0, master_enable},          32'd1);
    serve_one(4);
    check("w1_cap_reg",  {24'd0, cap_reg},  32'h05);
    check("w1_no_resp",  {31'd0, response_valid}, 32'd0);
    check("w1_idle_end", {31'd0, idle},     32'd1);

    // Write 3C to reg 02, then read it back
    set_cmd(1'b0, 7'h11, 8'h02, 8'h3C);
    tick();
    set_cmd(1'b1, 7'h11, 8'h02, 8'h00);
    tick();
    command_valid = 1'b0;
    serve_one(3);
    check("wr_cap_rw",   {31'd0, cap_rw},   32'd0);
    check("wr_cap_data", {24'd0, cap_data}, 32'h3C);
    serve_one(3);
    check("rd_cap_rw",   {31'd0, cap_rw},   32'd1);
    check("rd_cap_reg",  {24'd0, cap_reg},  32'h02);
    check("rd_rvalid",   {31'd0, response_valid}, 32'd1);
    check("rd_rdata",    {24'd0, response_data},  32'h3C);
    check("rd_rerr",     {31'd0, response_error}, 32'd0);

    // Response held 50 cycles with another command queued: nothing launches
    master_miso_data = 8'hFF;
    set_cmd(1'b0, 7'h11, 8'h07, 8'h55);
    tick();
    command_valid      = 1'b0;
    hold_enable_seen   = 1'b0;
    hold_data_moved    = 1'b0;
    hold_valid_dropped = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (master_enable) hold_enable_seen = 1'b1;
      if (response_data !== 8'h3C) hold_data_moved = 1'b1;
      if (response_valid !== 1'b1) hold_valid_dropped = 1'b1;
    end
    check("hold_no_launch", {31'd0, hold_enable_seen},   32'd0);
    check("hold_data",      {31'd0, hold_data_moved},    32'd0);
    check("hold_valid",     {31'd0, hold_valid_dropped}, 32'd0);
    check("hold_level",     {29'd0, fifo_level},         32'd1);
    response_ready = 1'b1;
    tick();
    response_ready = 1'b0;
    check("taken_rvalid", {31'd0, response_valid}, 32'd0);
    serve_one(2);
    check("after_cap_reg", {24'd0, cap_reg}, 32'h07);
    check("after_idle",    {31'd0, idle},    32'd1);

    // Fill with busy held: 4 accepted, 5th waits for the first pop
    master_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b0, 7'h11, 8'h10 + 8'(i), 8'hA0 + 8'(i));
      tick();
    end
    set_cmd(1'b0, 7'h11, 8'h14, 8'hA4);
    tick();
    tick();
    check("full_level", {29'd0, fifo_level},    32'd4);
    check("full_ready", {31'd0, command_ready},  32'd0);
    master_busy = 1'b0;
    tick();                                  // pop; 5th still refused this edge
    check("pop_level", {29'd0, fifo_level},    32'd3);
    check("pop_ready", {31'd0, command_ready}, 32'd1);
    tick();                                  // 5th accepted
    command_valid = 1'b0;
    check("fifth_level", {29'd0, fifo_level}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      serve_one(2);
      check("order_reg",  {24'd0, cap_reg},  32'h10 + 32'(i));
      check("order_data", {24'd0, cap_data}, 32'hA0 + 32'(i));
    end
    check("order_idle", {31'd0, idle}, 32'd1);

    // Asynchronous reset in WAIT_DONE with 3 queued
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 7'h22, 8'h30 + 8'(i), 8'h00);
      tick();
    end
    command_valid = 1'b0;
    check("pre_rst_en", {31'd0, master_enable}, 32'd1);
    master_busy = 1'b1;
    tick();
    check("pre_rst_level", {29'd0, fifo_level}, 32'd3);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_en",    {31'd0, master_enable},           32'd0);
    check("mid_rst_level", {29'd0, fifo_level},              32'd0);
    check("mid_rst_ready", {31'd0, command_ready},           32'd1);
    check("mid_rst_idle",  {31'd0, idle},                    32'd1);
    check("mid_rst_reg",   {24'd0, master_register_address}, 32'd0);
    master_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_en",  {31'd0, master_enable}, 32'd0);
    check("post_rst_idle", {31'd0, idle},         32'd1);

`ifdef I2C_COMMAND_QUEUE_TIMEOUT_EN
    // Busy never rises: abort on the 100th LAUNCH cycle
    set_cmd(1'b1, 7'h11, 8'h02, 8'h00);
    tick();
    command_valid = 1'b0;
    tick();                                  // LAUNCH entry
    repeat (99) tick();
    check("to_early_rvalid", {31'd0, response_valid}, 32'd0);
    tick();
    check("to_rvalid", {31'd0, response_valid}, 32'd1);
    check("to_rerr",   {31'd0, response_error}, 32'd1);
    check("to_rdata",  {24'd0, response_data},  32'd0);
    check("to_en",     {31'd0, master_enable},  32'd0);
    response_ready = 1'b1;
    tick();
    response_ready = 1'b0;
    check("to_rerr_clr", {31'd0, response_error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
